// File: rtl/mcd212_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mcd212_ram_arbiter
//  Purpose  : Single-port arbiter/sequencer for the MCD212 system DRAM.
//             Shares one RAM command port between the CPU (read/write,
//             byte lanes), the ICA/DCA control-table fetcher (read) and the
//             display-file pixel fetcher (read). Fixed priority
//             file > ica > cpu, with a starvation limit that forces a CPU
//             grant after CPU_STARVE_LIMIT consecutive video grants.
//  Ports    : clk, reset                 - clock, synchronous active-high reset
//             i_cpu_*  / o_cpu_*         - CPU request, data and ack
//             i_ica_*  / o_ica_*         - ICA fetch request, data and ack
//             i_file_* / o_file_*        - display-file request, data and ack
//             o_ram_*  / i_ram_rdata     - RAM command port and read data
//  Revision : 1.0 - initial release
// ============================================================================
module mcd212_ram_arbiter #(
   parameter int READ_LATENCY     = 2,
   parameter int CPU_STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_cpu_as,
   input  logic        i_cpu_write,
   input  logic        i_cpu_uds,
   input  logic        i_cpu_lds,
   input  logic [18:0] i_cpu_adr,
   input  logic [15:0] i_cpu_din,
   output logic [15:0] o_cpu_dout,
   output logic        o_cpu_bus_ack,
   input  logic        i_ica_as,
   input  logic [18:0] i_ica_adr,
   output logic [15:0] o_ica_dout,
   output logic        o_ica_bus_ack,
   input  logic        i_file_as,
   input  logic [18:0] i_file_adr,
   output logic [15:0] o_file_dout,
   output logic        o_file_bus_ack,
   output logic        o_ram_cs,
   output logic        o_ram_we,
   output logic [1:0]  o_ram_be,
   output logic [18:0] o_ram_addr,
   output logic [15:0] o_ram_wdata,
   input  logic [15:0] i_ram_rdata
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Requester ids double as bit positions in the mask vector.
   localparam logic [1:0] c_ID_CPU  = 2'd0;
   localparam logic [1:0] c_ID_ICA  = 2'd1;
   localparam logic [1:0] c_ID_FILE = 2'd2;
   localparam logic [3:0] c_LIMIT   = 4'(CPU_STARVE_LIMIT);
   localparam logic [3:0] c_LAST    = 4'(READ_LATENCY - 1);

   state_t      r_state;
   state_t      w_next;
   logic [1:0]  r_win;
   logic [18:0] r_addr;
   logic        r_we;
   logic [1:0]  r_be;
   logic [15:0] r_wdata;
   logic [3:0]  r_lat_cnt;
   logic [3:0]  r_starve;
   logic [2:0]  r_mask;
   logic [15:0] r_cpu_dout;
   logic [15:0] r_ica_dout;
   logic [15:0] r_file_dout;

   logic        w_cpu_eff;
   logic        w_ica_eff;
   logic        w_file_eff;
   logic        w_grant;
   logic [1:0]  w_win;
   logic        w_last_wait;

   // Winner selection and next state. The mask only exists to stop the
   // requester that was just acked from being re-granted in the IDLE cycle
   // right after its DONE, before it has had a chance to drop as.
   always_comb begin
      w_cpu_eff   = i_cpu_as & (i_cpu_uds | i_cpu_lds) & ~r_mask[c_ID_CPU];
      w_ica_eff   = i_ica_as  & ~r_mask[c_ID_ICA];
      w_file_eff  = i_file_as & ~r_mask[c_ID_FILE];
      w_grant     = w_cpu_eff | w_ica_eff | w_file_eff;
      w_last_wait = (r_lat_cnt == c_LAST);
      w_win       = c_ID_CPU;
      if (w_cpu_eff && (r_starve == c_LIMIT)) begin
         w_win = c_ID_CPU;
      end else if (w_file_eff) begin
         w_win = c_ID_FILE;
      end else if (w_ica_eff) begin
         w_win = c_ID_ICA;
      end

      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_grant) w_next = S_ISSUE;
         S_ISSUE: w_next = r_we ? S_DONE : S_WAIT;
         S_WAIT:  if (w_last_wait) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_win       <= c_ID_CPU;
         r_addr      <= '0;
         r_we        <= 1'b0;
         r_be        <= 2'b00;
         r_wdata     <= '0;
         r_lat_cnt   <= '0;
         r_starve    <= '0;
         r_mask      <= '0;
         r_cpu_dout  <= '0;
         r_ica_dout  <= '0;
         r_file_dout <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               r_mask <= '0;
               // Counts video grants that jumped ahead of a waiting CPU.
               if (!w_cpu_eff || (w_win == c_ID_CPU)) begin
                  r_starve <= '0;
               end else if (r_starve != c_LIMIT) begin
                  r_starve <= r_starve + 4'd1;
               end
               if (w_grant) begin
                  r_win <= w_win;
                  if (w_win == c_ID_CPU) begin
                     r_addr  <= i_cpu_adr;
                     r_we    <= i_cpu_write;
                     r_be    <= {i_cpu_uds, i_cpu_lds};
                     r_wdata <= i_cpu_din;
                  end else begin
                     r_addr <= (w_win == c_ID_ICA) ? i_ica_adr : i_file_adr;
                     r_we   <= 1'b0;
                     r_be   <= 2'b11;
                  end
               end
            end
            S_ISSUE: r_lat_cnt <= '0;
            S_WAIT: begin
               r_lat_cnt <= r_lat_cnt + 4'd1;
               if (w_last_wait) begin
                  case (r_win)
                     c_ID_CPU:  r_cpu_dout  <= i_ram_rdata;
                     c_ID_ICA:  r_ica_dout  <= i_ram_rdata;
                     default:   r_file_dout <= i_ram_rdata;
                  endcase
               end
            end
            S_DONE: r_mask <= 3'b001 << r_win;
            default: ;
         endcase
      end
   end

   assign o_ram_cs       = (r_state == S_ISSUE);
   assign o_ram_we       = (r_state == S_ISSUE) & r_we;
   assign o_ram_be       = (r_state == S_ISSUE) ? r_be : 2'b00;
   assign o_ram_addr     = r_addr;
   assign o_ram_wdata    = r_wdata;
   assign o_cpu_bus_ack  = (r_state == S_DONE) && (r_win == c_ID_CPU);
   assign o_ica_bus_ack  = (r_state == S_DONE) && (r_win == c_ID_ICA);
   assign o_file_bus_ack = (r_state == S_DONE) && (r_win == c_ID_FILE);
   assign o_cpu_dout     = r_cpu_dout;
   assign o_ica_dout     = r_ica_dout;
   assign o_file_dout    = r_file_dout;

endmodule
`default_nettype wire

// File: tb/tb_mcd212_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mcd212_ram_arbiter
//  Purpose  : Self-checking bench for mcd212_ram_arbiter. A transaction-level
//             model schedules, per grant, the cycle of the RAM strobe, the
//             read-data cycle and the ack cycle; every cycle the DUT outputs
//             are compared against that schedule. Directed scenarios add
//             hand-computed literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mcd212_ram_arbiter;
   localparam int RL  = 2;
   localparam int LIM = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_as = 0, cpu_write = 0, cpu_uds = 0, cpu_lds = 0;
   logic [18:0] cpu_adr = '0, ica_adr = '0, file_adr = '0;
   logic [15:0] cpu_din = '0, ram_rdata = '0;
   logic        ica_as = 0, file_as = 0;
   logic [15:0] cpu_dout, ica_dout, file_dout, ram_wdata;
   logic        cpu_bus_ack, ica_bus_ack, file_bus_ack, ram_cs, ram_we;
   logic [1:0]  ram_be;
   logic [18:0] ram_addr;

   mcd212_ram_arbiter #(.READ_LATENCY(RL), .CPU_STARVE_LIMIT(LIM)) dut (
      .clk(clk), .reset(reset),
      .i_cpu_as(cpu_as), .i_cpu_write(cpu_write), .i_cpu_uds(cpu_uds),
      .i_cpu_lds(cpu_lds), .i_cpu_adr(cpu_adr), .i_cpu_din(cpu_din),
      .o_cpu_dout(cpu_dout), .o_cpu_bus_ack(cpu_bus_ack),
      .i_ica_as(ica_as), .i_ica_adr(ica_adr), .o_ica_dout(ica_dout),
      .o_ica_bus_ack(ica_bus_ack),
      .i_file_as(file_as), .i_file_adr(file_adr), .o_file_dout(file_dout),
      .o_file_bus_ack(file_bus_ack),
      .o_ram_cs(ram_cs), .o_ram_we(ram_we), .o_ram_be(ram_be),
      .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   // Requesters: index 0 = cpu, 1 = ica, 2 = file.
   logic rq_as[3]   = '{0, 0, 0};
   int   rq_hold[3] = '{0, 0, 0};
   int   rq_left[3] = '{0, 0, 0};
   bit   rq_after[3] = '{0, 0, 0};
   bit   rq_cont[3]  = '{0, 0, 0};

   // Model state
   bit          started = 0;
   bit          e_valid = 0;
   int          e_id = 0, e_cs_cyc = -1, e_rd_cyc = -1, e_ack_cyc = -1;
   bit          e_we = 0;
   logic [1:0]  e_be = '0;
   logic [18:0] e_addr = '0;
   logic [15:0] e_wdata = '0, e_data = '0;
   int          m_free = 0, mask_cyc = -1, mask_id = 0, starve = 0, rst_cyc = -1;
   logic [15:0] exp_dout[3] = '{16'h0, 16'h0, 16'h0};
   logic [15:0] mem[int];

   // Observations for the directed literal checks
   int          cs_cnt = 0, last_cs_cyc = -1;
   logic [1:0]  last_be = '0;
   logic        last_we = 0;
   int          ack_cnt[3] = '{0, 0, 0};
   int          ack_cyc[3] = '{-1, -1, -1};
   int          ack_q[$];

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic [15:0] memrd(int a);
      if (mem.exists(a)) return mem[a];
      return 16'(a * 37) ^ 16'hA5C3;
   endfunction

   task automatic arbitrate(int c);
      bit eff[3];
      int w;
      logic [15:0] old;
      for (int r = 0; r < 3; r++) eff[r] = (c == mask_cyc) && (mask_id == r);
      eff[0] = cpu_as && (cpu_uds || cpu_lds) && !eff[0];
      eff[1] = ica_as && !eff[1];
      eff[2] = file_as && !eff[2];
      w = -1;
      if (eff[0] && starve == LIM) w = 0;
      else if (eff[2]) w = 2;
      else if (eff[1]) w = 1;
      else if (eff[0]) w = 0;
      if (!eff[0] || w == 0) starve = 0;
      else if (starve < LIM) starve++;
      if (w < 0) return;
      e_valid = 1; e_id = w; e_cs_cyc = c + 1;
      if (w == 0) begin
         e_addr = cpu_adr; e_we = cpu_write; e_be = {cpu_uds, cpu_lds}; e_wdata = cpu_din;
      end else begin
         e_addr = (w == 1) ? ica_adr : file_adr; e_we = 0; e_be = 2'b11;
      end
      if (e_we) begin
         old = memrd(int'(e_addr));
         mem[int'(e_addr)] = {e_be[1] ? e_wdata[15:8] : old[15:8],
                              e_be[0] ? e_wdata[7:0]  : old[7:0]};
         e_ack_cyc = c + 2;
      end else begin
         e_data = memrd(int'(e_addr));
         e_rd_cyc = c + 1 + RL;
         e_ack_cyc = c + 2 + RL;
      end
      m_free = e_ack_cyc + 1;
      mask_cyc = m_free;
      mask_id = w;
   endtask

   task automatic step_model();
      int c;
      logic acks[3];
      logic [15:0] d[3];
      bit in_cs;
      c = cyc;
      acks[0] = cpu_bus_ack; acks[1] = ica_bus_ack; acks[2] = file_bus_ack;
      d[0] = cpu_dout; d[1] = ica_dout; d[2] = file_dout;
      if (started) begin
         in_cs = e_valid && (c == e_cs_cyc);
         if (e_valid && c == e_ack_cyc && !e_we) exp_dout[e_id] = e_data;
         chk("ram_cs", 32'(ram_cs), 32'(in_cs));
         if (in_cs) begin
            chk("ram_we", 32'(ram_we), 32'(e_we));
            chk("ram_be", 32'(ram_be), 32'(e_be));
            chk("ram_addr", 32'(ram_addr), 32'(e_addr));
            if (e_we) chk("ram_wdata", 32'(ram_wdata), 32'(e_wdata));
         end
         for (int r = 0; r < 3; r++) begin
            chk($sformatf("ack%0d", r), 32'(acks[r]),
                32'(e_valid && c == e_ack_cyc && e_id == r));
            chk($sformatf("dout%0d", r), 32'(d[r]), 32'(exp_dout[r]));
         end
         if (c == rst_cyc) begin
            chk("rst_addr", 32'(ram_addr), 32'h0);
            chk("rst_wdata", 32'(ram_wdata), 32'h0);
            chk("rst_we_be", {29'h0, ram_we, ram_be}, 32'h0);
         end
         if (ram_cs) begin
            cs_cnt++; last_cs_cyc = c; last_be = ram_be; last_we = ram_we;
         end
         for (int r = 0; r < 3; r++) if (acks[r] === 1'b1) begin
            ack_cnt[r]++; ack_cyc[r] = c; ack_q.push_back(r);
         end
      end
      if (reset) begin
         started = 1; e_valid = 0; m_free = c + 1; starve = 0; mask_cyc = -1;
         rst_cyc = c + 1;
         for (int r = 0; r < 3; r++) exp_dout[r] = '0;
      end else if (started && c >= m_free) begin
         arbitrate(c);
      end
      for (int r = 0; r < 3; r++) if (acks[r] === 1'b1 && !rq_cont[r]) begin
         rq_after[r] = 1; rq_left[r] = rq_hold[r]; rq_hold[r] = 0;
      end
   endtask

   task automatic apply();
      cpu_as = rq_as[0]; ica_as = rq_as[1]; file_as = rq_as[2];
   endtask

   task automatic tick(int n = 1);
      repeat (n) begin
         @(negedge clk);
         step_model();
         @(posedge clk);
         cyc++;
         #1;
         for (int r = 0; r < 3; r++) if (rq_after[r]) begin
            if (rq_left[r] > 0) rq_left[r]--;
            else begin rq_as[r] = 0; rq_after[r] = 0; end
         end
         ram_rdata = (e_valid && cyc == e_rd_cyc) ? e_data : 16'($urandom);
         apply();
      end
   endtask

   task automatic req_cpu(bit wr, bit u, bit l, logic [18:0] a, logic [15:0] dw, int hold);
      cpu_write = wr; cpu_uds = u; cpu_lds = l; cpu_adr = a; cpu_din = dw;
      rq_as[0] = 1; rq_hold[0] = hold; apply();
   endtask

   task automatic req_vid(int r, logic [18:0] a, int hold);
      if (r == 1) ica_adr = a; else file_adr = a;
      rq_as[r] = 1; rq_hold[r] = hold; apply();
   endtask

   int t0, cs0, a0;
   int exp7[7] = '{2, 1, 2, 1, 0, 2, 1};

   initial begin
      mem[32'h10] = 16'hBEEF;
      tick(3);
      reset = 0;
      tick(2);

      // CPU read of 0x10: strobe at T+1, ack at T+4 with BEEF
      t0 = cyc; req_cpu(0, 1, 1, 19'h00010, 16'h0, 0);
      tick(8);
      chk("rd_cs_lat", 32'(last_cs_cyc - t0), 32'd1);
      chk("rd_we_be", {29'h0, last_we, last_be}, 32'h3);
      chk("rd_ack_lat", 32'(ack_cyc[0] - t0), 32'd4);
      chk("rd_dout", 32'(cpu_dout), 32'hBEEF);

      // Upper-byte write, then read it back
      t0 = cyc; req_cpu(1, 1, 0, 19'h00020, 16'h12AB, 0);
      tick(6);
      chk("wr_we_be", {29'h0, last_we, last_be}, 32'h6);
      chk("wr_ack_lat", 32'(ack_cyc[0] - t0), 32'd2);
      req_cpu(0, 1, 1, 19'h00020, 16'h0, 0);
      tick(8);
      chk("wr_readback_hi", 32'(cpu_dout[15:8]), 32'h12);

      // As with both byte enables low: never served
      cs0 = cs_cnt; req_cpu(0, 0, 0, 19'h00040, 16'h0, 0);
      tick(6);
      rq_as[0] = 0; apply();
      chk("no_be_cs", 32'(cs_cnt - cs0), 32'd0);

      // Three simultaneous requests: file, ica, cpu
      tick(2);
      ack_q.delete(); cs0 = cs_cnt;
      req_vid(2, 19'h00100, 0); req_vid(1, 19'h00200, 0);
      req_cpu(0, 1, 1, 19'h00300, 16'h0, 0);
      tick(25);
      chk("tri_cs", 32'(cs_cnt - cs0), 32'd3);
      chk("tri_n", 32'(ack_q.size()), 32'd3);
      if (ack_q.size() == 3)
         chk("tri_order", 32'((ack_q[0] << 8) | (ack_q[1] << 4) | ack_q[2]), 32'h210);

      // Continuous video traffic with a waiting CPU: starvation limit
      ack_q.delete();
      rq_cont[1] = 1; rq_cont[2] = 1;
      req_vid(2, 19'h00400, 0); req_vid(1, 19'h00500, 0);
      req_cpu(0, 1, 1, 19'h00600, 16'h0, 0);
      tick(50);
      rq_cont[1] = 0; rq_cont[2] = 0;
      tick(20);
      chk("starve_n", 32'(ack_q.size() >= 7), 32'd1);
      for (int i = 0; i < 7; i++)
         if (i < ack_q.size()) chk($sformatf("starve_seq%0d", i), 32'(ack_q[i]), 32'(exp7[i]));

      // as held one cycle past ack: masked, single access
      cs0 = cs_cnt; req_cpu(0, 1, 1, 19'h00700, 16'h0, 1);
      tick(15);
      chk("hold1_cs", 32'(cs_cnt - cs0), 32'd1);
      // as held two cycles past ack: second access
      cs0 = cs_cnt; req_cpu(0, 1, 1, 19'h00710, 16'h0, 2);
      tick(20);
      chk("hold2_cs", 32'(cs_cnt - cs0), 32'd2);

      // Reset during WAIT of an ica read
      a0 = ack_cnt[1]; req_vid(1, 19'h00800, 0);
      tick(2);
      reset = 1; rq_as[1] = 0; apply();
      tick(1);
      reset = 0;
      tick(8);
      chk("rst_no_ack", 32'(ack_cnt[1] - a0), 32'd0);
      chk("rst_ica_dout", 32'(ica_dout), 32'h0);
      req_vid(1, 19'h00010, 0);
      tick(10);
      chk("rst_after_ack", 32'(ack_cnt[1] - a0), 32'd1);
      chk("rst_after_dout", 32'(ica_dout), 32'hBEEF);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
